// File: rtl/blake_round_scheduler_pkg.sv
// ============================================================================
// Module   : blake_round_scheduler_pkg
// Brief    : Shared state encodings and default sizing for the BLAKE-512
//            round scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package blake_round_scheduler_pkg;

  localparam int c_NUM_ROUNDS   = 16;
  localparam int c_SIGMA_PERIOD = 10;
  localparam int c_ROUND_W      = 5;
  localparam int c_SIGMA_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/blake_round_scheduler_if.sv
// ============================================================================
// Module   : blake_round_scheduler_if
// Brief    : Handshake and strobe bundle between the scheduler (master) and
//            the front-end / round core (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface blake_round_scheduler_if
  import blake_round_scheduler_pkg::*;
#(
  parameter int ROUND_W = c_ROUND_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 init_load;
  logic                 round_en;
  logic                 step_diag;
  logic [ROUND_W-1:0]   round_idx;
  logic [c_SIGMA_W-1:0] sigma_idx;
  logic                 final_en;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, init_load, round_en, step_diag, round_idx, sigma_idx,
           final_en, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, init_load, round_en, step_diag, round_idx, sigma_idx,
           final_en, out_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/blake_round_scheduler_counter.sv
// ============================================================================
// Module   : blake_round_scheduler_counter
// Brief    : Round index, sigma row and half-step phase tracking with a
//            last-round flag. Macro BLAKE_HALF_STEP_EN splits each round
//            into a column cycle and a diagonal cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blake_round_scheduler_counter
  import blake_round_scheduler_pkg::*;
#(
  parameter int NUM_ROUNDS   = c_NUM_ROUNDS,
  parameter int SIGMA_PERIOD = c_SIGMA_PERIOD,
  parameter int ROUND_W      = c_ROUND_W
) (
  input  wire logic                 clk,
  input  wire logic                 rstb,
  input  wire logic                 clear,
  input  wire logic                 advance,
  output logic [ROUND_W-1:0]        round_idx,
  output logic [c_SIGMA_W-1:0]      sigma_idx,
  output logic                      phase,
  output logic                      last_round
);

  localparam logic [ROUND_W-1:0]   c_LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [c_SIGMA_W-1:0] c_LAST_SIGMA = c_SIGMA_W'(SIGMA_PERIOD - 1);

  logic [ROUND_W-1:0]   r_round;
  logic [c_SIGMA_W-1:0] r_sigma;
  logic                 w_phase;
  logic                 w_round_done;

`ifdef BLAKE_HALF_STEP_EN
  logic r_phase;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_phase <= 1'b0;
    end else if (clear) begin
      r_phase <= 1'b0;
    end else if (advance) begin
      r_phase <= ~r_phase;
    end
  end

  assign w_phase      = r_phase;
  // A round completes only once its diagonal half has run.
  assign w_round_done = r_phase;
`else
  assign w_phase      = 1'b0;
  assign w_round_done = 1'b1;
`endif

  // Sigma wraps by compare so no modulo hardware is needed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_round <= '0;
      r_sigma <= '0;
    end else if (clear) begin
      r_round <= '0;
      r_sigma <= '0;
    end else if (advance && w_round_done) begin
      r_round <= r_round + 1'b1;
      r_sigma <= (r_sigma == c_LAST_SIGMA) ? '0 : r_sigma + 1'b1;
    end
  end

  assign round_idx  = r_round;
  assign sigma_idx  = r_sigma;
  assign phase      = w_phase;
  assign last_round = (r_round == c_LAST_ROUND) && w_round_done;

endmodule

`default_nettype wire

// File: rtl/blake_round_scheduler.sv
// ============================================================================
// Module   : blake_round_scheduler
// Brief    : Sequences one BLAKE-512 compression: init strobe, NUM_ROUNDS
//            round strobes, finalization strobe, then holds the result valid.
//            Macro BLAKE_HALF_STEP_EN selects two cycles per round.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blake_round_scheduler
  import blake_round_scheduler_pkg::*;
#(
  parameter int NUM_ROUNDS   = c_NUM_ROUNDS,
  parameter int SIGMA_PERIOD = c_SIGMA_PERIOD,
  parameter int ROUND_W      = c_ROUND_W
) (
  input  wire logic                clk,
  input  wire logic                rstb,
  blake_round_scheduler_if.master  bus
);

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_init_load;
  logic                 r_round_en;
  logic                 r_final_en;
  logic                 r_out_valid;
  logic                 r_busy;

  logic                 w_in_round;
  logic                 w_last_round;
  logic                 w_cnt_clear;
  logic                 w_cnt_advance;
  logic [ROUND_W-1:0]   w_round_idx;
  logic [c_SIGMA_W-1:0] w_sigma_idx;
  logic                 w_phase;

  assign w_in_round    = (r_state == ST_ROUND);
  // Counters sit at zero outside ROUND and are cleared on the final round.
  assign w_cnt_clear   = !w_in_round || w_last_round;
  assign w_cnt_advance = w_in_round && !w_last_round;

  blake_round_scheduler_counter #(
    .NUM_ROUNDS   (NUM_ROUNDS),
    .SIGMA_PERIOD (SIGMA_PERIOD),
    .ROUND_W      (ROUND_W)
  ) u_counter (
    .clk        (clk),
    .rstb       (rstb),
    .clear      (w_cnt_clear),
    .advance    (w_cnt_advance),
    .round_idx  (w_round_idx),
    .sigma_idx  (w_sigma_idx),
    .phase      (w_phase),
    .last_round (w_last_round)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_init_load <= 1'b0;
      r_round_en  <= 1'b0;
      r_final_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_state     <= ST_INIT;
            r_in_ready  <= 1'b0;
            r_init_load <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_INIT: begin
          r_state     <= ST_ROUND;
          r_init_load <= 1'b0;
          r_round_en  <= 1'b1;
        end
        ST_ROUND: begin
          if (w_last_round) begin
            r_state    <= ST_FINAL;
            r_round_en <= 1'b0;
            r_final_en <= 1'b1;
          end
        end
        ST_FINAL: begin
          r_state     <= ST_HOLD;
          r_final_en  <= 1'b0;
          r_out_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_init_load <= 1'b0;
          r_round_en  <= 1'b0;
          r_final_en  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.init_load = r_init_load;
  assign bus.round_en  = r_round_en;
  assign bus.step_diag = w_phase;
  assign bus.round_idx = w_round_idx;
  assign bus.sigma_idx = w_sigma_idx;
  assign bus.final_en  = r_final_en;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_blake_round_scheduler.sv
// ============================================================================
// Module   : tb_blake_round_scheduler
// Brief    : Directed bench for blake_round_scheduler; expected timing follows
//            BLAKE_HALF_STEP_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_blake_round_scheduler;
  import blake_round_scheduler_pkg::*;

  localparam int c_NR = 16;
  localparam int c_SP = 10;
`ifdef BLAKE_HALF_STEP_EN
  localparam int c_CPR = 2;
`else
  localparam int c_CPR = 1;
`endif
  localparam int c_RCYC = c_NR * c_CPR;
  localparam int c_FIN  = c_RCYC + 2;
  localparam int c_OV   = c_RCYC + 3;
  localparam int c_PER  = c_RCYC + 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  blake_round_scheduler_if #(.ROUND_W(5)) bus_if ();

  blake_round_scheduler #(
    .NUM_ROUNDS   (c_NR),
    .SIGMA_PERIOD (c_SP),
    .ROUND_W      (5)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one block and follows it up to the first out_valid cycle.
  task automatic run_block(input string nm);
    int c, init_cyc, nrnd, fin_cyc, ov_cyc, seq_err, multi;
    init_cyc = -1; fin_cyc = -1; ov_cyc = -1;
    nrnd = 0; seq_err = 0; multi = 0;
    check_val({nm, "_in_ready"}, bus_if.in_ready, 1);
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    c = 1;
    while (ov_cyc < 0 && c <= 80) begin
      if (bus_if.init_load && init_cyc < 0) init_cyc = c;
      if (bus_if.round_en) begin
        if (c != 2 + nrnd) seq_err++;
        if (bus_if.round_idx !== 5'(nrnd / c_CPR)) seq_err++;
        if (bus_if.sigma_idx !== 4'((nrnd / c_CPR) % c_SP)) seq_err++;
        if (bus_if.step_diag !== 1'(nrnd % c_CPR)) seq_err++;
        nrnd++;
      end
      if (bus_if.final_en) fin_cyc = c;
      if (int'(bus_if.init_load) + int'(bus_if.round_en) + int'(bus_if.final_en) > 1) multi++;
      if (bus_if.out_valid) ov_cyc = c;
      else begin
        tick();
        c++;
      end
    end
    check_val({nm, "_init_cyc"},  init_cyc, 1);
    check_val({nm, "_round_cnt"}, nrnd, c_RCYC);
    check_val({nm, "_round_seq"}, seq_err, 0);
    check_val({nm, "_final_cyc"}, fin_cyc, c_FIN);
    check_val({nm, "_ov_cyc"},    ov_cyc, c_OV);
    check_val({nm, "_exclusive"}, multi, 0);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      if (bus_if.in_ready) break;
      tick();
    end
    check_val({nm, "_idle"}, bus_if.in_ready, 1);
  endtask

  initial begin
    int strobes, e_ov, e_rdy, e_str, found, prev, nload;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;

    // Reset state and quiet idle
    tick(); tick();
    check_val("rst_in_ready",  bus_if.in_ready, 1);
    check_val("rst_busy",      bus_if.busy, 0);
    check_val("rst_strobes",   {bus_if.init_load, bus_if.round_en, bus_if.final_en, bus_if.out_valid}, 0);
    check_val("rst_round_idx", bus_if.round_idx, 0);
    check_val("rst_sigma_idx", bus_if.sigma_idx, 0);
    rstb = 1'b1;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus_if.init_load || bus_if.round_en || bus_if.final_en || bus_if.out_valid || !bus_if.in_ready)
        strobes++;
    end
    check_val("idle_quiet", strobes, 0);

    // Single block, consumer always ready
    bus_if.out_ready = 1'b1;
    run_block("t2");
    tick();
    check_val("t2_ov_one_cycle", bus_if.out_valid, 0);
    check_val("t2_back_idle",    bus_if.in_ready, 1);

    // Back-pressure with a pending block
    bus_if.out_ready = 1'b0;
    run_block("t3");
    bus_if.in_valid = 1'b1;
    e_ov = 0; e_rdy = 0; e_str = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus_if.out_valid) e_ov++;
      if (bus_if.in_ready) e_rdy++;
      if (bus_if.init_load || bus_if.round_en || bus_if.final_en) e_str++;
    end
    check_val("t3_ov_held",   e_ov, 0);
    check_val("t3_rdy_low",   e_rdy, 0);
    check_val("t3_no_accept", e_str, 0);
    bus_if.out_ready = 1'b1;
    tick();
    check_val("t3_release_ready", bus_if.in_ready, 1);
    check_val("t3_release_ov",    bus_if.out_valid, 0);
    tick();
    check_val("t3_pending_init",  bus_if.init_load, 1);
    bus_if.in_valid = 1'b0;
    tick();
    wait_idle("t3");

    // Asynchronous reset in the middle of round 7
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.round_en && bus_if.round_idx == 5'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    check_val("t4_reach_r7", found, 1);
    rstb = 1'b0;
    #1;
    check_val("t4_rst_ready",  bus_if.in_ready, 1);
    check_val("t4_rst_busy",   bus_if.busy, 0);
    check_val("t4_rst_round",  bus_if.round_idx, 0);
    check_val("t4_rst_sigma",  bus_if.sigma_idx, 0);
    check_val("t4_rst_strobe", {bus_if.round_en, bus_if.final_en, bus_if.out_valid}, 0);
    tick(); tick();
    rstb = 1'b1;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.final_en || bus_if.out_valid) strobes++;
    end
    check_val("t4_no_partial", strobes, 0);
    run_block("t4b");
    tick();
    check_val("t4b_idle", bus_if.in_ready, 1);

    // Back-to-back with in_valid and out_ready tied high
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    prev = -1; nload = 0;
    for (int t = 0; t < 3 * c_PER + 5; t++) begin
      tick();
      if (bus_if.init_load) begin
        if (prev >= 0) check_val("t5_period", t - prev, c_PER);
        prev = t;
        nload++;
      end
    end
    check_val("t5_accepts", nload, 4);
    bus_if.in_valid = 1'b0;
    tick();
    wait_idle("t5");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
